// File: rtl/knight_tour_solver.sv
// Depth-first knight's-tour search on a BW x BH board with fixed move order.
// The committed move sequence is kept one-hot per step and read back by index.
module knight_tour_solver #(
    parameter  int BW       = 5,
    parameter  int BH       = 5,
    parameter  int MAX_ITER = 2**24-1,
    localparam int NSQ      = BW*BH,
    localparam int LAST     = NSQ-2,
    localparam int IW       = $clog2(NSQ)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          go,
    input  logic          abort,
    input  logic [2:0]    x_start,
    input  logic [2:0]    y_start,
    input  logic [IW-1:0] indx,
    output logic [7:0]    move,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic          timeout,
    output logic [23:0]   iter_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_INIT, S_TRY, S_BACK, S_FIN} state_t;

    state_t        state_q, state_d;
    logic [63:0]   visited_q, visited_d;
    logic [7:0]    last_move_q [0:LAST];
    logic [7:0]    last_move_d [0:LAST];
    logic [IW-1:0] move_num_q, move_num_d;
    logic [2:0]    xx_q, xx_d;
    logic [2:0]    yy_q, yy_d;
    logic [7:0]    move_try_q, move_try_d;
    logic [23:0]   iter_cnt_q, iter_cnt_d;
    logic          win_q, win_d;
    logic          tmo_q, tmo_d;

    function automatic logic signed [4:0] dx_of(input logic [7:0] m);
        case (m)
            8'h01:        return 5'sd1;
            8'h02:        return -5'sd1;
            8'h04, 8'h08: return -5'sd2;
            8'h10:        return -5'sd1;
            8'h20:        return 5'sd1;
            8'h40, 8'h80: return 5'sd2;
            default:      return 5'sd0;
        endcase
    endfunction

    function automatic logic signed [4:0] dy_of(input logic [7:0] m);
        case (m)
            8'h01, 8'h02: return 5'sd2;
            8'h04:        return 5'sd1;
            8'h08:        return -5'sd1;
            8'h10, 8'h20: return -5'sd2;
            8'h40:        return -5'sd1;
            8'h80:        return 5'sd1;
            default:      return 5'sd0;
        endcase
    endfunction

    // Squares are addressed as {y, x} in a fixed 8x8 map; only in-board bits are ever set.
    logic signed [4:0] tx, ty;
    logic [5:0]        cur_idx, tgt_idx;
    logic              tgt_legal, start_ok, budget_hit;
    logic [23:0]       iter_inc;
    logic [IW-1:0]     back_k;
    logic [7:0]        back_m;

    assign tx         = $signed({2'b00, xx_q}) + dx_of(move_try_q);
    assign ty         = $signed({2'b00, yy_q}) + dy_of(move_try_q);
    assign cur_idx    = {yy_q, xx_q};
    assign tgt_idx    = {ty[2:0], tx[2:0]};
    assign tgt_legal  = !tx[4] && (tx[3:0] < 4'(BW)) && !ty[4] && (ty[3:0] < 4'(BH))
                        && !visited_q[tgt_idx];
    assign start_ok   = ({1'b0, x_start} < 4'(BW)) && ({1'b0, y_start} < 4'(BH));
    assign iter_inc   = (iter_cnt_q == 24'hFF_FFFF) ? iter_cnt_q : iter_cnt_q + 24'd1;
    assign budget_hit = (iter_inc >= 24'(MAX_ITER));
    assign back_k     = move_num_q - IW'(1);
    assign back_m     = last_move_q[back_k];

    always_comb begin
        state_d     = state_q;
        visited_d   = visited_q;
        last_move_d = last_move_q;
        move_num_d  = move_num_q;
        xx_d        = xx_q;
        yy_d        = yy_q;
        move_try_d  = move_try_q;
        iter_cnt_d  = iter_cnt_q;
        win_d       = win_q;
        tmo_d       = tmo_q;

        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        win_d      = 1'b0;
                        tmo_d      = 1'b0;
                        iter_cnt_d = '0;
                        if (start_ok) begin
                            visited_d  = '0;
                            move_num_d = '0;
                            xx_d       = x_start;
                            yy_d       = y_start;
                            for (int i = 0; i <= LAST; i++) last_move_d[i] = 8'h00;
                            state_d    = S_INIT;
                        end else begin
                            state_d = S_FIN;
                        end
                    end
                end
                S_INIT: begin
                    visited_d[cur_idx] = 1'b1;
                    move_try_d         = 8'h01;
                    state_d            = S_TRY;
                end
                S_TRY: begin
                    iter_cnt_d = iter_inc;
                    if (budget_hit) begin
                        tmo_d   = 1'b1;
                        state_d = S_FIN;
                    end else if (tgt_legal) begin
                        last_move_d[move_num_q] = move_try_q;
                        visited_d[tgt_idx]      = 1'b1;
                        xx_d                    = tx[2:0];
                        yy_d                    = ty[2:0];
                        move_try_d              = 8'h01;
                        if (move_num_q == IW'(LAST)) begin
                            win_d   = 1'b1;
                            state_d = S_FIN;
                        end else begin
                            move_num_d = move_num_q + IW'(1);
                        end
                    end else if (move_try_q != 8'h80) begin
                        move_try_d = move_try_q << 1;
                    end else begin
                        state_d = S_BACK;
                    end
                end
                S_BACK: begin
                    iter_cnt_d = iter_inc;
                    if (budget_hit) begin
                        tmo_d   = 1'b1;
                        state_d = S_FIN;
                    end else if (move_num_q == '0) begin
                        state_d = S_FIN;
                    end else begin
                        // Undo the most recent committed step and resume with its successor.
                        visited_d[cur_idx]  = 1'b0;
                        xx_d                = xx_q - 3'(dx_of(back_m));
                        yy_d                = yy_q - 3'(dy_of(back_m));
                        last_move_d[back_k] = 8'h00;
                        move_num_d          = back_k;
                        if (back_m != 8'h80) begin
                            move_try_d = back_m << 1;
                            state_d    = S_TRY;
                        end
                    end
                end
                S_FIN: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            visited_q  <= '0;
            move_num_q <= '0;
            xx_q       <= '0;
            yy_q       <= '0;
            move_try_q <= 8'h01;
            iter_cnt_q <= '0;
            win_q      <= 1'b0;
            tmo_q      <= 1'b0;
            for (int i = 0; i <= LAST; i++) last_move_q[i] <= 8'h00;
        end else begin
            state_q    <= state_d;
            visited_q  <= visited_d;
            move_num_q <= move_num_d;
            xx_q       <= xx_d;
            yy_q       <= yy_d;
            move_try_q <= move_try_d;
            iter_cnt_q <= iter_cnt_d;
            win_q      <= win_d;
            tmo_q      <= tmo_d;
            for (int i = 0; i <= LAST; i++) last_move_q[i] <= last_move_d[i];
        end
    end

    assign move     = (int'(indx) <= LAST) ? last_move_q[indx] : 8'h00;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_FIN) && win_q;
    assign fail     = (state_q == S_FIN) && !win_q;
    assign timeout  = (state_q == S_FIN) && tmo_q;
    assign iter_cnt = iter_cnt_q;

endmodule

// File: tb/tb_knight_tour_solver.sv
// Bench for knight_tour_solver: a 5x5 engine with a small budget and a 4x3 engine
// with the full budget, both compared against a plain depth-first search model.
module tb_knight_tour_solver;
    localparam int BW_A = 5, BH_A = 5, MX_A = 4000, IW_A = $clog2(BW_A*BH_A);
    localparam int BW_B = 4, BH_B = 3, MX_B = 2**24-1, IW_B = $clog2(BW_B*BH_B);

    logic clk = 1'b0, rst_n = 1'b0, abort = 1'b0;
    logic go_a = 1'b0, go_b = 1'b0;
    logic [2:0] xs = 3'd0, ys = 3'd0;
    logic [IW_A-1:0] indx_a = '0;
    logic [IW_B-1:0] indx_b = '0;
    logic [7:0]  move_a, move_b;
    logic        busy_a, done_a, fail_a, timeout_a;
    logic        busy_b, done_b, fail_b, timeout_b;
    logic [23:0] iter_a, iter_b;

    knight_tour_solver #(.BW(BW_A), .BH(BH_A), .MAX_ITER(MX_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .go(go_a), .abort(abort), .x_start(xs), .y_start(ys),
        .indx(indx_a), .move(move_a), .busy(busy_a), .done(done_a), .fail(fail_a),
        .timeout(timeout_a), .iter_cnt(iter_a));

    knight_tour_solver #(.BW(BW_B), .BH(BH_B), .MAX_ITER(MX_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .go(go_b), .abort(abort), .x_start(xs), .y_start(ys),
        .indx(indx_b), .move(move_b), .busy(busy_b), .done(done_b), .fail(fail_b),
        .timeout(timeout_b), .iter_cnt(iter_b));

    always #5 clk = ~clk;

    logic sel = 1'b0;
    wire        busy_s = sel ? busy_b    : busy_a;
    wire        done_s = sel ? done_b    : done_a;
    wire        fail_s = sel ? fail_b    : fail_a;
    wire        tmo_s  = sel ? timeout_b : timeout_a;
    wire [7:0]  move_s = sel ? move_b    : move_a;
    wire [23:0] iter_s = sel ? iter_b    : iter_a;

    int checks = 0, errors = 0;
    int DXT [0:7] = '{1, -1, -2, -2, -1, 1, 2, 2};
    int DYT [0:7] = '{2, 2, 1, -1, -2, -2, -1, 1};

    // Reference results: res 0 = tour, 1 = no tour / bad start, 2 = budget exhausted.
    int exp_stk [0:63];
    int exp_dep, exp_cyc, exp_res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Plain DFS: every candidate examined costs a cycle, every retreat costs a cycle.
    task automatic run_model(input int bw, input int bh, input int sx, input int sy, input int mx);
        bit vis [0:7][0:7];
        int x, y, tx, ty, d, m;
        bit found;
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) vis[i][j] = 1'b0;
        for (int i = 0; i < 64; i++) exp_stk[i] = -1;
        x = sx; y = sy; vis[x][y] = 1'b1; d = 0; tx = 0; ty = 0;
        exp_dep = 0; exp_cyc = 0; exp_res = -1;
        while (exp_res < 0) begin
            found = 1'b0;
            while (exp_res < 0 && !found && d < 8) begin
                exp_cyc++;
                if (exp_cyc >= mx) exp_res = 2;
                else begin
                    tx = x + DXT[d];
                    ty = y + DYT[d];
                    if (tx >= 0 && tx < bw && ty >= 0 && ty < bh && !vis[tx][ty]) found = 1'b1;
                    else d++;
                end
            end
            if (exp_res < 0) begin
                if (found) begin
                    exp_stk[exp_dep] = d;
                    vis[tx][ty] = 1'b1;
                    x = tx; y = ty; d = 0;
                    exp_dep++;
                    if (exp_dep == bw*bh-1) exp_res = 0;
                end else begin
                    exp_cyc++;
                    if (exp_cyc >= mx) exp_res = 2;
                    else if (exp_dep == 0) exp_res = 1;
                    else begin
                        exp_dep--;
                        m = exp_stk[exp_dep];
                        exp_stk[exp_dep] = -1;
                        vis[x][y] = 1'b0;
                        x = x - DXT[m];
                        y = y - DYT[m];
                        d = m + 1;
                    end
                end
            end
        end
    endtask

    task automatic set_go(input logic v);
        if (sel) go_b = v; else go_a = v;
    endtask

    task automatic set_indx(input int i);
        indx_a = IW_A'(i);
        indx_b = IW_B'(i);
    endtask

    task automatic do_search(input bit s, input int sx, input int sy, input int again_at);
        int bw, bh, mx, nind, fin_exp, fin_at, nd, nf, nt, x, y, b, ok;
        bit legal;
        logic b_fin, b_after;
        bit seen [0:7][0:7];
        logic [7:0] mv;
        sel = s;
        bw = s ? BW_B : BW_A;
        bh = s ? BH_B : BH_A;
        mx = s ? MX_B : MX_A;
        nind = s ? 2**IW_B : 2**IW_A;
        legal = (sx < bw) && (sy < bh);
        if (legal) begin
            run_model(bw, bh, sx, sy, mx);
            fin_exp = exp_cyc + 2;
        end else begin
            exp_res = 1; exp_cyc = 0; exp_dep = 0;
            fin_exp = 1;
        end
        fin_at = -1; nd = 0; nf = 0; nt = 0; b_fin = 1'b0; b_after = 1'b1;
        @(negedge clk);
        xs = 3'(sx); ys = 3'(sy);
        set_go(1'b1);
        for (int t = 1; t <= fin_exp + 3; t++) begin
            @(negedge clk);
            set_go(t == again_at);
            if (t == again_at) begin
                xs = 3'(bw - 1); ys = 3'(bh - 1);
            end
            if (done_s) nd++;
            if (fail_s) nf++;
            if (tmo_s)  nt++;
            if ((done_s || fail_s) && fin_at < 0) fin_at = t;
            if (t == fin_exp)     b_fin   = busy_s;
            if (t == fin_exp + 1) b_after = busy_s;
        end
        set_go(1'b0);
        chk("fin_cycle", fin_at, fin_exp);
        chk("done_pulses", nd, (exp_res == 0) ? 1 : 0);
        chk("fail_pulses", nf, (exp_res != 0) ? 1 : 0);
        chk("timeout_pulses", nt, (exp_res == 2) ? 1 : 0);
        chk("busy_in_fin", b_fin, 1);
        chk("busy_after_fin", b_after, 0);
        chk("iter_cnt", iter_s, exp_cyc);
        if (legal) begin
            for (int i = 0; i < nind; i++) begin
                set_indx(i);
                #1;
                chk("move", move_s, (i < exp_dep) ? (32'h1 << exp_stk[i]) : 32'h0);
            end
        end
        if (legal && exp_res == 0) begin
            for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) seen[i][j] = 1'b0;
            x = sx; y = sy; seen[x][y] = 1'b1; ok = 0;
            for (int i = 0; i < bw*bh-1; i++) begin
                set_indx(i);
                #1;
                mv = move_s;
                b = -1;
                for (int k = 0; k < 8; k++) if (mv == (8'h01 << k)) b = k;
                if (b >= 0) begin
                    x = x + DXT[b];
                    y = y + DYT[b];
                    if (x >= 0 && x < bw && y >= 0 && y < bh && !seen[x][y]) begin
                        seen[x][y] = 1'b1;
                        ok++;
                    end
                end
            end
            chk("replay_squares", ok, bw*bh-1);
        end
        $display("search board=%0dx%0d start=(%0d,%0d) result=%0d iter=%0d fin_cycle=%0d",
                 bw, bh, sx, sy, exp_res, exp_cyc, fin_exp);
    endtask

    task automatic do_abort(input int sx, input int sy, input int at);
        logic b1, b2;
        int npulse;
        sel = 1'b0; npulse = 0; b1 = 1'b0; b2 = 1'b1;
        @(negedge clk);
        xs = 3'(sx); ys = 3'(sy); go_a = 1'b1;
        for (int t = 1; t <= at + 20; t++) begin
            @(negedge clk);
            go_a = 1'b0;
            abort = (t == at);
            if (done_a || fail_a) npulse++;
            if (t == at)     b1 = busy_a;
            if (t == at + 1) b2 = busy_a;
        end
        abort = 1'b0;
        chk("abort_busy_before", b1, 1);
        chk("abort_busy_after", b2, 0);
        chk("abort_no_pulse", npulse, 0);
        $display("abort start=(%0d,%0d) at_cycle=%0d", sx, sy, at);
    endtask

    task automatic check_reset_values(input string where);
        chk({where, "_busy"}, {busy_a, busy_b}, 0);
        chk({where, "_done"}, {done_a, done_b}, 0);
        chk({where, "_fail"}, {fail_a, fail_b}, 0);
        chk({where, "_timeout"}, {timeout_a, timeout_b}, 0);
        chk({where, "_iter_a"}, iter_a, 0);
        chk({where, "_iter_b"}, iter_b, 0);
        for (int i = 0; i < 4; i++) begin
            set_indx(i);
            #1;
            chk({where, "_move"}, {move_a, move_b}, 0);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int rx, ry;
        #12;
        check_reset_values("reset");
        $display("reset check done");
        @(negedge clk);
        rst_n = 1'b1;

        // Corner start with a second go injected mid-search that must be ignored.
        do_search(1'b0, 0, 0, 10);
        do_search(1'b0, 0, 1, 0);
        for (int n = 0; n < 2; n++) begin
            rx = int'($urandom_range(0, 4));
            ry = int'($urandom_range(0, 4));
            do_search(1'b0, rx, ry, 0);
        end

        do_abort(0, 0, 20);
        do_search(1'b0, 5, 2, 0);
        do_search(1'b0, int'($urandom_range(5, 7)), int'($urandom_range(0, 7)), 0);

        // Asynchronous reset in the middle of a search.
        sel = 1'b0;
        @(negedge clk);
        xs = 3'd0; ys = 3'd0; go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        $display("mid-search reset check done");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int yy = 0; yy < BH_B; yy++)
            for (int xx = 0; xx < BW_B; xx++)
                do_search(1'b1, xx, yy, 0);
        do_search(1'b1, 4, 1, 0);
        do_search(1'b1, 1, 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/knight_tour_solver.md
# knight_tour_solver

- Parametrised backtracking knight's-tour engine for a BW x BH board, 3 to 8 squares per side.
- Given a start square, it searches depth-first in fixed move order for an open tour visiting every square once, and stores the move sequence for random-access readout by the move-replay logic.
- Unlike the fixed 5x5 solver, it:
  - reports failure when no tour exists, when the start square is illegal, or when the search exceeds an iteration budget;
  - supports abort;
  - exposes busy and step-count status.

## Interface
- BW, 5: board width (x), 3..8.
- BH, 5: board height (y), 3..8.
- MAX_ITER, 2**24-1: iteration budget in TRY/BACK cycles; exceeding it forces failure.
- Derived: NSQ = BW*BH, LAST = NSQ-2 (index of final move), IW = $clog2(NSQ).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- go  in  1  start search; sampled only in IDLE.
- abort  in  1  terminate search; returns to IDLE.
- x_start  in  3  start column.
- y_start  in  3  start row.
- indx  in  IW  readout index of move.
- move  out  8  one-hot move stored at indx; 8'h00 if indx > LAST.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse: tour complete.
- fail  out  1  one-cycle pulse: no tour, illegal start, or budget exceeded.
- timeout  out  1  one-cycle pulse, coincident with fail, only when the budget was exceeded.
- iter_cnt  out  24  TRY+BACK cycles of the current/last search, saturating.

## Operation
- Move encoding, bit:(dx,dy):
  - 0:(+1,+2), 1:(-1,+2), 2:(-2,+1), 3:(-2,-1)
  - 4:(-1,-2), 5:(+1,-2), 6:(+2,-1), 7:(+2,+1)
- Candidates are tried in ascending bit order.
- Legality:
  - Target = (xx+dx, yy+dy), computed as 5-bit signed.
  - The target is legal iff 0 <= x < BW, 0 <= y < BH, and visited[x][y] == 0.
  - No modular wrap is allowed.
- Storage:
  - visited: BW x BH bits.
  - last_move[0..LAST]: 8 bits each.
  - move_num: IW bits.
  - xx, yy: 3 bits each.
  - move_try: 8 bits, one-hot.
- States: IDLE, INIT, TRY, BACK, FIN.
- IDLE:
  - go with x_start < BW and y_start < BH: clear visited, last_move, move_num and iter_cnt; go to INIT.
  - go with an out-of-range start: go to FIN with fail set.
- INIT:
  - Mark start square visited; xx/yy <= start; move_try <= 8'h01.
  - Go to TRY.
- TRY (one candidate per cycle):
  - Candidate legal:
    - last_move[move_num] <= move_try; mark target visited; move to target; move_try <= 8'h01.
    - If move_num == LAST, go to FIN with done set; otherwise move_num++ and stay in TRY.
  - Candidate illegal and move_try != 8'h80: shift move_try left by one.
  - Candidate illegal and move_try == 8'h80: go to BACK.
- BACK:
  - If move_num == 0 and no entry is committed at index 0: go to FIN with fail set.
  - Otherwise, with m = last_move[k], where k is the last committed index:
    - clear visited[xx][yy] and step back by -offset(m);
    - clear last_move[k] to 8'h00; move_num <= k.
  - If m != 8'h80: move_try <= m<<1 and go to TRY.
  - If m == 8'h80: stay in BACK.
- FIN: pulse done or fail (and timeout when applicable) for exactly one cycle; go to IDLE.
- Budget: iter_cnt increments each TRY/BACK cycle. When it reaches MAX_ITER in TRY or BACK, go to FIN with fail and timeout set.
- abort:
  - Any non-IDLE state goes to IDLE next cycle, with no done or fail pulse.
  - The tables keep their partial contents.
  - abort has priority over all other transitions.
- go while busy: ignored.
- The move table and iter_cnt hold after FIN until the next accepted go.

## Timing
- Reset values:
  - state IDLE; busy = 0, done = 0, fail = 0, timeout = 0; iter_cnt = 0.
  - move = 8'h00 for every indx, because last_move is cleared.
- Reset mid-search returns to IDLE immediately and asynchronously.
- Latencies after go:
  - go sampled at edge 0; busy high from edge 0.
  - INIT occupies cycle 1; first TRY in cycle 2.
  - Illegal start: fail high in cycle 1, busy low in cycle 2.
- done/fail are asserted during FIN, one cycle after the terminating TRY/BACK cycle; busy is still high during FIN and drops on the following edge.
- move is combinational from indx; it is valid any time busy == 0.
- The flat cost model (one cycle per candidate or backtrack step) is relied on by the bench's cycle-exact model.

## Test plan
- BW=BH=5, go with start (0,0):
  - done pulses exactly once; fail never asserts.
  - move[0..23] all one-hot; move[24..31] == 8'h00.
  - Replaying the 24 moves from (0,0) visits all 25 squares once, in bounds.
  - move sequence and iter_cnt match the C reference model exactly.
- BW=BH=4, start (0,0): fail pulses, timeout == 0, done never asserts (4x4 has no open tour); busy returns low.
- BW=BH=5, start (0,1) (odd-colour square, no tour): fail pulses with timeout == 0.
- BW=BH=5, start (5,2): fail at cycle 1 after go, busy low at cycle 2, iter_cnt == 0.
- MAX_ITER=100, BW=BH=5, start (0,0): fail and timeout pulse together; iter_cnt == 100.
- Mid-search checks:
  - abort at cycle 50: busy low at cycle 51, no done or fail.
  - go pulse at cycle 20 during a search: no restart.
  - rst_n low mid-search: all outputs at reset values immediately.
